window_sum_ctrl: RTL
====================

# window_sum_ctrl

Controller for the 2^N-sample sliding-window adder datapath. It accepts a sample stream over a valid/ready handshake and owns the history buffer and running sum. It gates results through a warm-up phase, so that a sum is emitted only once the window holds 2^N real samples. It sits between an upstream sample source and a downstream consumer and replaces the free-running, handshake-less adder in stream paths that need back-pressure and clearing.

## Interface
- DW, 8: sample width.
- N, 4: log2 of window length; window WIN = 2**N samples.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- clr  in  1  synchronous window clear; one-cycle pulse or held.
- in_valid  in  1  sample offered.
- in_ready  out  1  controller can accept a sample this cycle.
- in_data  in  DW  sample, unsigned.
- out_valid  out  1  window sum available.
- out_ready  in  1  consumer accepts the sum.
- out_sum  out  DW+N  sum of the WIN most recently accepted samples, unsigned, full precision.
- full  out  1  window holds WIN samples (state RUN).

## Operation
- States:
  - FILL (reset state): fewer than WIN samples held.
  - RUN: window full.
- fill_cnt counts from 0 to WIN-1 in FILL.
- Accept = in_valid && in_ready.
  - Each accept writes in_data at wr_ptr.
  - wr_ptr increments mod WIN and wraps naturally.
- Running sum: sum_next = sum + in_data - oldest.
  - oldest = buffer[wr_ptr] in RUN; forced 0 in FILL, so the buffer never needs zeroing.
- FILL:
  - in_ready = !clr.
  - Accepts produce no output.
  - The accept with fill_cnt == WIN-1 moves to RUN and loads the output register with the first full sum.
- RUN:
  - in_ready = !clr && (!out_valid || out_ready).
  - Every accept loads out_sum with sum_next and sets out_valid.
  - Output handshake without a same-cycle accept clears out_valid.
- clr:
  - Next cycle: sum=0, fill_cnt=0, wr_ptr=0, out_valid=0, state FILL.
  - A pending undelivered result is discarded.
  - clr has priority over a same-cycle accept; in_ready is low, so nothing is lost silently.
- Width: out_sum is DW+N bits, and WIN*(2^DW-1) always fits. No overflow or truncation is possible.
- While out_valid && !out_ready, out_sum and out_valid hold stable.

## Timing
- Reset (rst_n low at posedge): out_valid=0, out_sum=0, full=0, state FILL, fill_cnt=0, wr_ptr=0, sum=0.
- in_ready is low during the reset cycle.
- Latency: sample accepted at edge t gives out_valid=1 and out_sum including it after edge t (visible in cycle t+1).
- Throughput: one sample per cycle in RUN while out_ready stays high.
- in_ready is combinational from out_valid, out_ready and clr. There is no combinational path from in_valid to in_ready.
- full asserts in the same cycle as the first out_valid.
- A reset mid-burst behaves exactly like a clr, plus it clears any optional counters.

## Configuration
- WINDOW_SUM_CTRL_STALL_CNT_EN defined:
  - Adds output stall_cnt, 16 bits.
  - stall_cnt counts cycles with out_valid && !out_ready and saturates at 0xFFFF.
  - It resets to 0 on rst_n low; clr does not reset it.
- Undefined: port and counter absent; behaviour otherwise identical.

## Structure
- Package window_sum_pkg holds:
  - the state enum (FILL, RUN);
  - the SW = DW+N width helper;
  - the stall counter width constant (16).
- Sub-module window_sum_hist: WIN x DW circular buffer.
  - Write port: data, enable, address wr_ptr.
  - Asynchronous read of the same address, so the read returns the oldest entry before overwrite.
  - No reset on the storage.
- Top level holds the FSM, fill_cnt, wr_ptr, running sum, output register and the optional counter.

## Test plan
- Reset, N=4, DW=8, feed 1..16 with out_ready=1:
  - no out_valid for the first 15 accepts;
  - after the 16th, out_sum=136, full=1.
- Continue with 17, 18: out_sum=152, then 168 (oldest 1, then 2 subtracted).
- In RUN, hold out_ready=0 for 3 cycles with in_valid=1:
  - in_ready=0 and out_sum stable throughout;
  - on release, no sample is lost or duplicated (sequence sums continue +16 per step);
  - with the macro defined, stall_cnt=3.
- Pulse clr with in_valid=1 mid-stream:
  - that sample is not accepted; out_valid=0, full=0;
  - then 16 samples of 255 give out_sum=4080 (12 bits, no overflow).
- Assert rst_n=0 while out_valid=1 and out_ready=0:
  - next cycle all outputs are at reset values;
  - a new fill of 16 twos gives out_sum=32.
- Wrap check: stream 40 consecutive samples. Every out_sum equals a reference model's sum of the last 16; wr_ptr wraps twice without error.

Source files
------------

// File: rtl/window_sum_ctrl_pkg.sv
// Shared types and width helpers for the sliding-window sum controller.
// Package window_sum_pkg: FSM state enum, sum-width helper, stall counter width.
package window_sum_pkg;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int STALL_W = 16;

    // Full-precision width of a sum of 2**n samples of dw bits each.
    function automatic int sum_w(input int dw, input int n);
        return dw + n;
    endfunction

endpackage

// File: rtl/window_sum_ctrl_if.sv
// Sample-in / sum-out valid-ready stream bundle for window_sum_ctrl.
// master = source/consumer side, slave = the controller.
interface window_sum_ctrl_if
    import window_sum_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DW-1:0]              in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [sum_w(DW, N)-1:0]    out_sum;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum
    );

endinterface

// File: rtl/window_sum_hist.sv
// WIN x DW circular history buffer with a single address for write and read.
// The read is asynchronous, so it returns the entry about to be overwritten.
module window_sum_hist #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [N-1:0]  i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);
    localparam int WIN = 1 << N;

    logic [DW-1:0] r_mem [WIN];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_sum_ctrl.sv
// Sliding-window (2**N samples) sum controller with valid/ready handshake and clear.
// Optional macro WINDOW_SUM_CTRL_STALL_CNT_EN adds a saturating output-stall counter.
module window_sum_ctrl
    import window_sum_pkg::*;
#(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    window_sum_ctrl_if.slave    bus,
    output logic                o_full
`ifdef WINDOW_SUM_CTRL_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]  o_stall_cnt
`endif
);
    localparam int SW = sum_w(DW, N);

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_fill_cnt;
    logic [N-1:0]   r_wr_ptr;
    logic [SW-1:0]  r_sum;
    logic [SW-1:0]  r_out_sum;
    logic           r_out_valid;
    logic [SW-1:0]  w_sum_next;
    logic [DW-1:0]  w_hist_rd;
    logic [DW-1:0]  w_oldest;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_load;

    window_sum_hist #(
        .DW (DW),
        .N  (N)
    ) u_hist (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_wr_ptr),
        .i_wdata (bus.in_data),
        .o_rdata (w_hist_rd)
    );

    // Buffer contents are stale until the window has filled once, so mask them in FILL.
    assign w_oldest   = (r_state == RUN) ? w_hist_rd : '0;
    assign w_sum_next = r_sum + SW'(bus.in_data) - SW'(w_oldest);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        if (!i_rst_n || i_clr) begin
            w_next_state = FILL;
        end else begin
            case (r_state)
                FILL: begin
                    w_in_ready = 1'b1;
                    w_accept   = bus.in_valid;
                    // fill_cnt all-ones means this accept completes the window
                    if (w_accept && (r_fill_cnt == '1)) begin
                        w_load       = 1'b1;
                        w_next_state = RUN;
                    end
                end
                RUN: begin
                    w_in_ready = !r_out_valid || bus.out_ready;
                    w_accept   = bus.in_valid && w_in_ready;
                    w_load     = w_accept;
                end
                default: begin
                    w_next_state = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_fill_cnt  <= '0;
            r_wr_ptr    <= '0;
            r_sum       <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sum    <= w_sum_next;
                r_wr_ptr <= r_wr_ptr + N'(1);
                if (r_state == FILL) begin
                    r_fill_cnt <= r_fill_cnt + N'(1);
                end
            end
            if (w_load) begin
                r_out_sum   <= w_sum_next;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef WINDOW_SUM_CTRL_STALL_CNT_EN
    logic [STALL_W-1:0] r_stall_cnt;

    // Survives clr on purpose: it is a lifetime back-pressure statistic.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign o_full        = (r_state == RUN);

endmodule
